// File: rtl/v_rams_port_arb_pkg.sv
// Shared definitions for the port-A controller/arbiter of the 128x16 dual-port RAM.
// Holds default widths, the clear/run state encoding and the requester IDs.
package v_rams_port_arb_pkg;

  localparam int AW_DEF = 7;
  localparam int DW_DEF = 16;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/v_rams_port_arb_rr_arb2.sv
// Two-input round-robin arbiter. The requester that did not win most recently
// takes priority when both ask; `last` starts at REQ1 so requester 0 goes first.
module rr_arb2
  import v_rams_port_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic r_last;
  logic w_id;

  // NOTE: every output of a combinational block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_id = REQ0;
    gnt  = 2'b00;
    if (req == 2'b11) begin
      w_id = ~r_last;
    end else if (req[1]) begin
      w_id = REQ1;
    end
    if (enable && (|req)) begin
      gnt = (w_id == REQ1) ? 2'b10 : 2'b01;
    end
  end

  assign gnt_id = w_id;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= REQ1;
    end else if (|gnt) begin
      r_last <= w_id;
    end
  end

endmodule

// File: rtl/v_rams_port_arb.sv
// Port-A controller for the 128x16 write-first RAM: clears the array after reset,
// then arbitrates two requesters and returns read data tagged with the requester ID.
module v_rams_port_arb
  import v_rams_port_arb_pkg::*;
#(
  parameter int             AW       = AW_DEF,
  parameter int             DW       = DW_DEF,
  parameter logic [DW-1:0]  INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          rd_valid,
  output logic          rd_id,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          ram_we,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_di,
  input  logic [DW-1:0] ram_spo
);

  state_e        r_state, w_state_nxt;
  logic [AW-1:0] r_clr_cnt;
  logic [AW-1:0] r_ram_a_hold;
  logic          r_rd_valid;
  logic          r_rd_id;
  logic [1:0]    w_gnt;
  logic          w_gnt_id;
  logic          w_rd_issue;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({r1_req, r0_req}),
    .enable (r_state == RUN),
    .gnt    (w_gnt),
    .gnt_id (w_gnt_id)
  );

  always_comb begin
    w_state_nxt = r_state;
    if ((r_state == CLEAR) && (r_clr_cnt == '1)) begin
      w_state_nxt = RUN;
    end
  end

  // Idle RUN cycles keep the last address so the RAM re-latches the same location.
  always_comb begin
    ram_we     = 1'b0;
    ram_a      = r_ram_a_hold;
    ram_di     = INIT_VAL;
    w_rd_issue = 1'b0;
    if (r_state == CLEAR) begin
      ram_we = 1'b1;
      ram_a  = r_clr_cnt;
    end else if (|w_gnt) begin
      ram_we     = (w_gnt_id == REQ1) ? r1_we    : r0_we;
      ram_a      = (w_gnt_id == REQ1) ? r1_addr  : r0_addr;
      ram_di     = (w_gnt_id == REQ1) ? r1_wdata : r0_wdata;
      w_rd_issue = ~ram_we;
    end
  end

  // NOTE: the RAM array itself has no reset; it is initialised by the clear sweep,
  // and only these control flops are reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= CLEAR;
      r_clr_cnt    <= '0;
      r_ram_a_hold <= '0;
      r_rd_valid   <= 1'b0;
      r_rd_id      <= REQ0;
    end else begin
      r_state      <= w_state_nxt;
      r_ram_a_hold <= ram_a;
      r_rd_valid   <= w_rd_issue;
      if (r_state == CLEAR) begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
      end
      if (w_rd_issue) begin
        r_rd_id <= w_gnt_id;
      end
    end
  end

  assign r0_gnt   = w_gnt[0];
  assign r1_gnt   = w_gnt[1];
  assign busy     = (r_state == CLEAR);
  assign rd_valid = r_rd_valid;
  assign rd_id    = r_rd_id;
  assign rd_data  = ram_spo;

endmodule

// File: tb/tb_v_rams_port_arb.sv
// Self-checking bench for v_rams_port_arb with a behavioural write-first RAM on port A,
// a round-robin reference model and a read-return scoreboard.
module tb_v_rams_port_arb;

  localparam int AW = 7;
  localparam int DW = 16;

  typedef struct {
    logic          id;
    logic [DW-1:0] data;
  } rd_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          r0_req, r0_we, r1_req, r1_we;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata;
  logic          r0_gnt, r1_gnt, rd_valid, rd_id, busy, ram_we;
  logic [DW-1:0] rd_data, ram_di, ram_spo;
  logic [AW-1:0] ram_a;

  int n_vec = 0;
  int n_err = 0;

  logic          m_last;
  logic [AW-1:0] m_last_a;
  logic [DW-1:0] ref_mem [2**AW];
  rd_t           exp_q [$];

  always #5 clk = ~clk;

  v_rams_port_arb dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .r0_req   (r0_req),
    .r0_we    (r0_we),
    .r0_addr  (r0_addr),
    .r0_wdata (r0_wdata),
    .r0_gnt   (r0_gnt),
    .r1_req   (r1_req),
    .r1_we    (r1_we),
    .r1_addr  (r1_addr),
    .r1_wdata (r1_wdata),
    .r1_gnt   (r1_gnt),
    .rd_valid (rd_valid),
    .rd_id    (rd_id),
    .rd_data  (rd_data),
    .busy     (busy),
    .ram_we   (ram_we),
    .ram_a    (ram_a),
    .ram_di   (ram_di),
    .ram_spo  (ram_spo)
  );

  // Write-first RAM with registered read address, as the external block behaves.
  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] ram_ra;
  always @(posedge clk) begin
    if (ram_we) mem[ram_a] <= ram_di;
    ram_ra <= ram_a;
  end
  assign ram_spo = mem[ram_ra];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a falling edge during CLEAR; checks n sweep cycles.
  task automatic clear_sweep(input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      check("clr_busy",   busy,     1);
      check("clr_we",     ram_we,   1);
      check("clr_a",      ram_a,    i);
      check("clr_di",     ram_di,   0);
      check("clr_r0_gnt", r0_gnt,   0);
      check("clr_r1_gnt", r1_gnt,   0);
      check("clr_rd_vld", rd_valid, 0);
      @(negedge clk);
    end
  endtask

  // One RUN cycle: drive at the falling edge, check against the model, advance the model.
  task automatic step(input logic q0, input logic w0, input logic [AW-1:0] a0,
                      input logic [DW-1:0] d0, input logic q1, input logic w1,
                      input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    logic          g0, g1, win, we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    rd_t           e;
    r0_req = q0; r0_we = w0; r0_addr = a0; r0_wdata = d0;
    r1_req = q1; r1_we = w1; r1_addr = a1; r1_wdata = d1;
    #1;
    if (q0 && q1) begin
      g0 = m_last;
      g1 = ~m_last;
    end else begin
      g0 = q0;
      g1 = q1;
    end
    win = g1;
    we  = win ? w1 : w0;
    a   = win ? a1 : a0;
    d   = win ? d1 : d0;
    check("busy",   busy,   0);
    check("r0_gnt", r0_gnt, g0);
    check("r1_gnt", r1_gnt, g1);
    if (g0 || g1) begin
      check("ram_we", ram_we, we);
      check("ram_a",  ram_a,  a);
      if (we) check("ram_di", ram_di, d);
    end else begin
      check("ram_we_idle", ram_we, 0);
      check("ram_a_hold",  ram_a,  m_last_a);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rd_valid", rd_valid, 1);
      check("rd_id",    rd_id,    e.id);
      check("rd_data",  rd_data,  e.data);
    end else begin
      check("rd_valid", rd_valid, 0);
    end
    if (g0 || g1) begin
      m_last   = win;
      m_last_a = a;
      if (we) begin
        ref_mem[a] = d;
      end else begin
        e.id   = win;
        e.data = ref_mem[a];
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    r0_req = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0;
    r1_req = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0;
    m_last = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy",   busy,     1);
    check("rst_rd_vld", rd_valid, 0);
    check("rst_rd_id",  rd_id,    0);
    check("rst_r0_gnt", r0_gnt,   0);
    check("rst_r1_gnt", r1_gnt,   0);

    // First sweep, interrupted by reset at clear cycle 40.
    @(negedge clk);
    rst_n = 1'b1;
    clear_sweep(40);
    rst_n  = 1'b0;
    r0_req = 1; r0_we = 0; r0_addr = 7'h05;
    #1;
    check("midclr_busy",   busy,     1);
    check("midclr_a",      ram_a,    0);
    check("midclr_rd_vld", rd_valid, 0);
    check("midclr_r0_gnt", r0_gnt,   0);
    repeat (2) @(negedge clk);

    // Full sweep with r0 holding a read request throughout.
    rst_n = 1'b1;
    clear_sweep(128);
    for (int i = 0; i < 2**AW; i++) ref_mem[i] = '0;
    m_last_a = 7'h7F;

    step(1, 0, 7'h05, 0, 0, 0, 0, 0);          // early request granted in first RUN cycle
    step(0, 0, 0, 0, 1, 0, 7'h7F, 0);          // read of last cleared address
    step(0, 0, 0, 0, 1, 1, 7'h12, 16'hBEEF);   // write then read-after-write
    step(0, 0, 0, 0, 1, 0, 7'h12, 0);
    idle();

    for (int k = 0; k < 6; k++) begin          // continuous contention
      step(1, 0, AW'(k), 0, 1, 0, 7'h12, 0);
    end
    idle();

    step(1, 1, 7'h03, 16'h1111, 1, 0, 7'h04, 0);  // r0 write vs r1 read
    step(0, 0, 0, 0, 1, 0, 7'h04, 0);
    idle();
    step(1, 0, 7'h03, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 7'h12, 0);

    // Reset while a read return is on the outputs.
    #1;
    check("midrd_vld_pre", rd_valid, 1);
    rst_n = 1'b0;
    #1;
    check("midrd_vld",  rd_valid, 0);
    check("midrd_id",   rd_id,    0);
    check("midrd_busy", busy,     1);
    exp_q.delete();
    m_last = 1'b1;
    r0_req = 0; r1_req = 0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_sweep(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
